// File: rtl/ipml_arb_pkg.sv
// Shared definitions for the round-robin arbiter in front of the sync FIFO:
// FSM state encoding, buffer depth and the wrapping round-robin increment.
package ipml_arb_pkg;

  localparam int unsigned BUF_DEPTH = 2;

  typedef enum logic {
    ST_ARB,
    ST_LOCK
  } arb_state_e;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ipml_arb_reg_slice.sv
// Two-entry ping-pong valid/ready buffer. in_ready depends only on registered
// occupancy, so a full buffer never admits a write even while it is being read.
module ipml_arb_reg_slice
  import ipml_arb_pkg::*;
#(
  parameter int unsigned PW = 35
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);

  logic [PW-1:0]        r_mem [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] r_vld;
  logic [PTR_W-1:0]     r_wr;
  logic [PTR_W-1:0]     r_rd;
  logic                 w_wr;
  logic                 w_rd;

  assign in_ready  = ~&r_vld;
  assign out_valid = r_vld[r_rd];
  assign out_data  = r_mem[r_rd];
  assign w_wr      = in_valid & in_ready;
  assign w_rd      = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      // A write and a read never target the same entry: writes go to an empty slot.
      if (w_wr) begin
        r_mem[r_wr] <= in_data;
        r_vld[r_wr] <= 1'b1;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_rd) begin
        r_vld[r_rd] <= 1'b0;
        r_rd        <= r_rd + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ipml_rr_arb_sync_fifo.sv
// N-input round-robin arbiter feeding a 2-entry register buffer (sync FIFO front end).
// Define IPML_ARB_PKT_LOCK_EN for packet-atomic grants; otherwise arbitration is per beat.
module ipml_rr_arb_sync_fifo
  import ipml_arb_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned W    = 32,
  parameter int unsigned ID_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    s_valid,
  input  logic [N*W-1:0]  s_data,
  input  logic [N-1:0]    s_last,
  output logic [N-1:0]    s_ready,
  output logic            m_valid,
  output logic [W-1:0]    m_data,
  output logic [ID_W-1:0] m_id,
  output logic            m_last,
  input  logic            m_ready,
  output logic            busy
);

  localparam int unsigned PW = W + ID_W + 1;

  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] w_hi;
  logic [ID_W-1:0] w_lo;
  logic            w_hi_vld;
  logic            w_lo_vld;
  logic [ID_W-1:0] w_gnt;
  logic [ID_W-1:0] w_sel;
  logic            w_sel_vld;
  logic            w_sel_valid_in;
  logic            w_sel_last;
  logic [W-1:0]    w_sel_data;
  logic            w_in_ready;
  logic            w_acc;
  logic            w_out_valid;
  logic [PW-1:0]   w_in_pl;
  logic [PW-1:0]   w_out_pl;

`ifdef IPML_ARB_PKT_LOCK_EN
  arb_state_e      r_state;
  logic [ID_W-1:0] r_owner;
  logic            w_locked;
  assign w_locked = (r_state == ST_LOCK);
`endif

  // Rotating priority: lowest valid index >= ptr wins, else lowest valid index overall.
  always_comb begin
    w_hi_vld = 1'b0;
    w_lo_vld = 1'b0;
    w_hi     = '0;
    w_lo     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (s_valid[i] && !w_hi_vld && (ID_W'(i) >= r_ptr)) begin
        w_hi_vld = 1'b1;
        w_hi     = ID_W'(i);
      end
      if (s_valid[i] && !w_lo_vld) begin
        w_lo_vld = 1'b1;
        w_lo     = ID_W'(i);
      end
    end
  end

  assign w_gnt = w_hi_vld ? w_hi : w_lo;

`ifdef IPML_ARB_PKT_LOCK_EN
  // While locked the owner is offered in_ready even with s_valid low, so nobody else is served.
  assign w_sel     = w_locked ? r_owner : w_gnt;
  assign w_sel_vld = w_locked | w_lo_vld;
`else
  assign w_sel     = w_gnt;
  assign w_sel_vld = w_lo_vld;
`endif

  always_comb begin
    s_ready        = '0;
    w_sel_valid_in = 1'b0;
    w_sel_last     = 1'b0;
    w_sel_data     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (ID_W'(i) == w_sel) begin
        w_sel_valid_in = s_valid[i];
        w_sel_last     = s_last[i];
        w_sel_data     = s_data[i*W +: W];
        s_ready[i]     = !rst && w_sel_vld && w_in_ready;
      end
    end
  end

  assign w_acc   = !rst && w_sel_vld && w_in_ready && w_sel_valid_in;
  assign w_in_pl = {w_sel_last, w_sel, w_sel_data};

  ipml_arb_reg_slice #(
    .PW (PW)
  ) u_slice (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w_acc),
    .in_ready  (w_in_ready),
    .in_data   (w_in_pl),
    .out_valid (w_out_valid),
    .out_ready (m_ready),
    .out_data  (w_out_pl)
  );

  assign m_valid                 = w_out_valid;
  assign {m_last, m_id, m_data}  = w_out_pl;

`ifdef IPML_ARB_PKT_LOCK_EN
  assign busy = w_locked | w_out_valid;
`else
  assign busy = w_out_valid;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
`ifdef IPML_ARB_PKT_LOCK_EN
      r_state <= ST_ARB;
      r_owner <= '0;
`endif
    end else if (w_acc) begin
`ifdef IPML_ARB_PKT_LOCK_EN
      if (w_sel_last) begin
        r_ptr   <= ID_W'(rr_next(32'(w_sel), N));
        r_state <= ST_ARB;
      end else if (!w_locked) begin
        r_owner <= w_sel;
        r_state <= ST_LOCK;
      end
`else
      r_ptr <= ID_W'(rr_next(32'(w_sel), N));
`endif
    end
  end

endmodule

// File: tb/tb_ipml_rr_arb_sync_fifo.sv
// Self-checking bench for ipml_rr_arb_sync_fifo: a vector table plus directed sequences,
// with a reference arbiter model feeding a scoreboard of expected output beats.
module tb_ipml_rr_arb_sync_fifo;

  localparam int N    = 4;
  localparam int W    = 32;
  localparam int ID_W = 2;

  logic            clk;
  logic            rst;
  logic [N-1:0]    s_valid;
  logic [N*W-1:0]  s_data;
  logic [N-1:0]    s_last;
  logic [N-1:0]    s_ready;
  logic            m_valid;
  logic [W-1:0]    m_data;
  logic [ID_W-1:0] m_id;
  logic            m_last;
  logic            m_ready;
  logic            busy;

  ipml_rr_arb_sync_fifo #(
    .N    (N),
    .W    (W),
    .ID_W (ID_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_last  (s_last),
    .s_ready (s_ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_id    (m_id),
    .m_last  (m_last),
    .m_ready (m_ready),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]    d;
    logic [ID_W-1:0] id;
    logic            l;
  } beat_t;

  typedef struct {
    logic [N-1:0] sv;
    logic [N-1:0] sl;
    logic         mr;
    logic [N-1:0] rdy;
    logic         mv;
    logic [1:0]   mid;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  beat_t sb[$];
  int    got_id[$];
  int    got_last[$];

  int           m_ptr;
  int           m_cnt;
  bit           m_lock;
  int           m_owner;
  logic [N-1:0] acc_mask;
  logic [N-1:0] last_acc;
  int           nacc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference model: evaluated at the falling edge, its state then reflects the next rising edge.
  task automatic model_check();
    int           g;
    bit           gv;
    bit           acc;
    bit           rd;
    logic [N-1:0] er;
    beat_t        b;
    g  = 0;
    gv = 0;
    if (m_lock) begin
      g  = m_owner;
      gv = 1;
    end else begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (!gv && s_valid[idx]) begin
          g  = idx;
          gv = 1;
        end
      end
    end
    er = '0;
    if (gv && m_cnt < 2) er[g] = 1'b1;
    chk("s_ready", s_ready, er);
    chk("m_valid", m_valid, m_cnt > 0);
    chk("busy", busy, (m_cnt > 0) || m_lock);
    acc = gv && (m_cnt < 2) && s_valid[g];
    rd  = (m_cnt > 0) && m_ready;
    if (|(s_valid & s_ready)) nacc++;
    if (m_valid && m_ready) begin
      got_id.push_back(int'(m_id));
      got_last.push_back(int'(m_last));
    end
    if (rd && sb.size() > 0) begin
      b = sb.pop_front();
      chk("m_data", m_data, b.d);
      chk("m_id", m_id, b.id);
      chk("m_last", m_last, b.l);
    end
    if (acc) begin
      b.d  = s_data[g*W +: W];
      b.id = g[ID_W-1:0];
      b.l  = s_last[g];
      sb.push_back(b);
      acc_mask[g] = 1'b1;
    end
    m_cnt = m_cnt + int'(acc) - int'(rd);
`ifdef IPML_ARB_PKT_LOCK_EN
    if (acc) begin
      if (s_last[g]) begin
        m_ptr  = (g + 1) % N;
        m_lock = 0;
      end else if (!m_lock) begin
        m_owner = g;
        m_lock  = 1;
      end
    end
`else
    if (acc) m_ptr = (g + 1) % N;
`endif
  endtask

  task automatic at_neg();
    @(negedge clk);
    model_check();
  endtask

  task automatic at_pos();
    @(posedge clk);
    #1;
    last_acc = acc_mask;
    acc_mask = '0;
    for (int i = 0; i < N; i++)
      if (last_acc[i]) s_data[i*W +: W] = s_data[i*W +: W] + 1;
  endtask

  task automatic cycle();
    at_neg();
    at_pos();
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    s_valid = '1;
    s_last  = '1;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_id", m_id, 0);
    chk("rst_m_last", m_last, 0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    s_valid  = '0;
    m_ptr    = 0;
    m_cnt    = 0;
    m_lock   = 0;
    m_owner  = 0;
    acc_mask = '0;
    sb.delete();
    got_id.delete();
    got_last.delete();
  endtask

  vec_t tbl[6];

  initial begin
    int b1;
    int drop;
    bit got2;

    tbl[0] = '{sv: 4'hF, sl: 4'hF, mr: 1'b1, rdy: 4'b0001, mv: 1'b0, mid: 2'd0};
    tbl[1] = '{sv: 4'hF, sl: 4'hF, mr: 1'b1, rdy: 4'b0010, mv: 1'b1, mid: 2'd0};
    tbl[2] = '{sv: 4'hF, sl: 4'hF, mr: 1'b1, rdy: 4'b0100, mv: 1'b1, mid: 2'd1};
    tbl[3] = '{sv: 4'hF, sl: 4'hF, mr: 1'b1, rdy: 4'b1000, mv: 1'b1, mid: 2'd2};
    tbl[4] = '{sv: 4'hF, sl: 4'hF, mr: 1'b1, rdy: 4'b0001, mv: 1'b1, mid: 2'd3};
    tbl[5] = '{sv: 4'hF, sl: 4'hF, mr: 1'b1, rdy: 4'b0010, mv: 1'b1, mid: 2'd0};

    rst     = 1'b1;
    s_valid = '0;
    s_last  = '0;
    m_ready = 1'b0;
    for (int i = 0; i < N; i++) s_data[i*W +: W] = {8'(i + 1), 24'h0};
    acc_mask = '0;
    nacc     = 0;

    // Round-robin over single-beat packets
    do_reset();
    for (int r = 0; r < 6; r++) begin
      s_valid = tbl[r].sv;
      s_last  = tbl[r].sl;
      m_ready = tbl[r].mr;
      at_neg();
      chk($sformatf("tbl%0d_s_ready", r), s_ready, tbl[r].rdy);
      chk($sformatf("tbl%0d_m_valid", r), m_valid, tbl[r].mv);
      if (tbl[r].mv) chk($sformatf("tbl%0d_m_id", r), m_id, tbl[r].mid);
      at_pos();
    end
    s_valid = '0;
    repeat (3) cycle();

    // Backpressure: two beats fill the buffer, then everything stalls
    do_reset();
    s_valid = 4'b1001;
    s_last  = 4'b1111;
    m_ready = 1'b0;
    nacc    = 0;
    repeat (3) cycle();
    at_neg();
    chk("bp_accepts", nacc, 2);
    chk("bp_ready_frozen", s_ready, 0);
    at_pos();
    s_valid = '0;
    m_ready = 1'b1;
    repeat (3) cycle();
    chk("bp_out_count", got_id.size(), 2);
    if (got_id.size() == 2) begin
      chk("bp_first_id", got_id[0], 0);
      chk("bp_second_id", got_id[1], 3);
    end
    s_valid = 4'b1001;
    at_neg();
    chk("bp_resume_grant", s_ready, 4'b0001);
    at_pos();
    s_valid = '0;
    repeat (3) cycle();

`ifdef IPML_ARB_PKT_LOCK_EN
    // Packet lock: requester 1 sends 3 beats with a gap; requester 2 waits throughout
    do_reset();
    m_ready = 1'b1;
    b1      = 0;
    drop    = 0;
    got2    = 0;
    for (int c = 0; c < 10; c++) begin
      s_valid[1] = (b1 < 3) && !(b1 == 1 && drop < 3);
      s_last[1]  = (b1 == 2);
      s_valid[2] = !got2;
      s_last[2]  = 1'b1;
      at_neg();
      if (b1 == 1 && drop < 3) begin
        chk("lock_hold_no_accept", s_valid & s_ready, 0);
        drop++;
      end
      if (b1 < 3) chk("lock_r2_blocked", s_ready[2], 0);
      at_pos();
      if (last_acc[1]) b1++;
      if (last_acc[2]) got2 = 1;
    end
    chk("lock_out_count", got_id.size(), 4);
    if (got_id.size() == 4) begin
      chk("lock_id0", got_id[0], 1);
      chk("lock_id1", got_id[1], 1);
      chk("lock_id2", got_id[2], 1);
      chk("lock_id3", got_id[3], 2);
    end
`else
    // Per-beat arbitration: open packets from 0 and 2 interleave
    do_reset();
    s_valid = 4'b0101;
    s_last  = 4'b0000;
    m_ready = 1'b1;
    repeat (5) cycle();
    chk("alt_out_count", got_id.size(), 4);
    if (got_id.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("alt_id%0d", i), got_id[i], (i % 2 == 0) ? 0 : 2);
        chk($sformatf("alt_last%0d", i), got_last[i], 0);
      end
    end
    s_valid = '0;
    repeat (3) cycle();
`endif

    // Random traffic with held valids and random backpressure
    do_reset();
    s_last = '0;
    for (int c = 0; c < 200; c++) begin
      s_valid = s_valid & ~last_acc;
      for (int i = 0; i < N; i++) begin
        if (!s_valid[i] && $urandom_range(0, 1) == 1) begin
          s_valid[i] = 1'b1;
          s_last[i]  = ($urandom_range(0, 2) == 0);
        end
      end
      m_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    s_valid = '0;
    m_ready = 1'b1;
    repeat (4) cycle();
    chk("drain_scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
